// File: rtl/riscv_div_ctrl_pkg.sv
// Shared RISC-V defines: divider opcode encoding and divider-control FSM states.
package riscv_defines;

    typedef enum logic [1:0] {
        DIV_OP_UDIV = 2'd0,
        DIV_OP_DIV  = 2'd1,
        DIV_OP_UREM = 2'd2,
        DIV_OP_REM  = 2'd3
    } divOpCode_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE  = 2'd0,
        DIV_ST_ISSUE = 2'd1,
        DIV_ST_WAIT  = 2'd2,
        DIV_ST_RESP  = 2'd3
    } divState_e;

endpackage

// File: rtl/riscv_div_ctrl_if.sv
// Request/response bus between the pipeline (master) and the divider controller (slave).
interface riscv_div_ctrl_if #(
  parameter int C_WIDTH     = 32,
  parameter int C_TAG_WIDTH = 5
);
  logic                   ReqVld_SI;
  logic                   ReqRdy_SO;
  logic [C_WIDTH-1:0]     ReqOpA_DI;
  logic [C_WIDTH-1:0]     ReqOpB_DI;
  logic [1:0]             ReqOpCode_SI;
  logic [C_TAG_WIDTH-1:0] ReqTag_DI;
  logic                   Flush_SI;
  logic                   RspVld_SO;
  logic                   RspRdy_SI;
  logic [C_WIDTH-1:0]     RspRes_DO;
  logic [C_TAG_WIDTH-1:0] RspTag_DO;

  modport master (
    output ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOpCode_SI, ReqTag_DI, Flush_SI, RspRdy_SI,
    input  ReqRdy_SO, RspVld_SO, RspRes_DO, RspTag_DO
  );

  modport slave (
    input  ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOpCode_SI, ReqTag_DI, Flush_SI, RspRdy_SI,
    output ReqRdy_SO, RspVld_SO, RspRes_DO, RspTag_DO
  );
endinterface

// File: rtl/riscv_div_lzc.sv
// Leading-bit counter: number of MSB-side bits equal to CountOnes_SI (0..C_WIDTH).
module riscv_div_lzc #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic [C_WIDTH-1:0]     Operand_DI,
  input  logic                   CountOnes_SI,
  output logic [C_LOG_WIDTH-1:0] Count_DO
);
  logic done_S;

  // Scan from the MSB and stop counting at the first differing bit
  always_comb begin
    Count_DO = {C_LOG_WIDTH{1'b0}};
    done_S   = 1'b0;
    for (int i = C_WIDTH-1; i >= 0; i--) begin
      if (!done_S && (Operand_DI[i] == CountOnes_SI)) begin
        Count_DO = Count_DO + C_LOG_WIDTH'(1);
      end else begin
        done_S = 1'b1;
      end
    end
  end
endmodule

// File: rtl/riscv_div_ctrl.sv
// Sequencer between the pipeline and the serial divider: registers operands,
// normalises the divisor, hands off to riscv_alu_div and returns the tagged result.
module riscv_div_ctrl
  import riscv_defines::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6,
  parameter int C_TAG_WIDTH = 5
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  riscv_div_ctrl_if.slave        Bus,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI,
  output logic                   Busy_SO
);
  localparam logic [1:0] S_IDLE  = DIV_ST_IDLE;
  localparam logic [1:0] S_ISSUE = DIV_ST_ISSUE;
  localparam logic [1:0] S_WAIT  = DIV_ST_WAIT;
  localparam logic [1:0] S_RESP  = DIV_ST_RESP;

  logic [1:0]             stateDP, stateDN;
  logic                   dropDP, dropDN, dropSet_S;
  logic [C_WIDTH-1:0]     opADP, opADN, opBDP, opBDN, resDP, resDN;
  logic [1:0]             opCodeDP, opCodeDN;
  logic [C_TAG_WIDTH-1:0] tagDP, tagDN;
  logic                   reqRdy_S, divInVld_S, divOutRdy_S, rspVld_S;
  logic                   opBSign_S, opBZero_S;
  logic [C_LOG_WIDTH-1:0] lzcCnt_S, shift_S;

  assign opBSign_S = opCodeDP[0] & opBDP[C_WIDTH-1];
  assign opBZero_S = (opBDP == {C_WIDTH{1'b0}});

  riscv_div_lzc #(
    .C_WIDTH     (C_WIDTH),
    .C_LOG_WIDTH (C_LOG_WIDTH)
  ) i_lzc (
    .Operand_DI   (opBDP),
    .CountOnes_SI (opBSign_S),
    .Count_DO     (lzcCnt_S)
  );

  // Negative divisors keep one sign bit at the MSB after normalisation
  assign shift_S = opBZero_S ? C_LOG_WIDTH'(C_WIDTH-1) :
                   (opBSign_S ? (lzcCnt_S - C_LOG_WIDTH'(1)) : lzcCnt_S);

  assign dropSet_S = Bus.Flush_SI & ((stateDP == S_ISSUE) | (stateDP == S_WAIT));

  // Next-state and handshake decode
  always_comb begin
    stateDN     = stateDP;
    opADN       = opADP;
    opBDN       = opBDP;
    opCodeDN    = opCodeDP;
    tagDN       = tagDP;
    resDN       = resDP;
    reqRdy_S    = 1'b0;
    divInVld_S  = 1'b0;
    divOutRdy_S = 1'b0;
    rspVld_S    = 1'b0;
    case (stateDP)
      S_IDLE: begin
        reqRdy_S = ~Bus.Flush_SI;
        if (Bus.ReqVld_SI && !Bus.Flush_SI) begin
          opADN    = Bus.ReqOpA_DI;
          opBDN    = Bus.ReqOpB_DI;
          opCodeDN = Bus.ReqOpCode_SI;
          tagDN    = Bus.ReqTag_DI;
          stateDN  = S_ISSUE;
        end else begin
          stateDN  = S_IDLE;
        end
      end
      S_ISSUE: begin
        divInVld_S = 1'b1;
        stateDN    = S_WAIT;
      end
      S_WAIT: begin
        divOutRdy_S = DivOutVld_SI;
        if (DivOutVld_SI && (dropDP || Bus.Flush_SI)) begin
          stateDN = S_IDLE;
        end else if (DivOutVld_SI) begin
          resDN   = DivRes_DI;
          stateDN = S_RESP;
        end else begin
          stateDN = S_WAIT;
        end
      end
      S_RESP: begin
        rspVld_S = 1'b1;
        if (Bus.RspRdy_SI || Bus.Flush_SI) begin
          stateDN = S_IDLE;
        end else begin
          stateDN = S_RESP;
        end
      end
      default: begin
        stateDN = S_IDLE;
      end
    endcase
    dropDN = (stateDN == S_IDLE) ? 1'b0 : (dropDP | dropSet_S);
  end

  // State, operand, tag and result registers
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      stateDP  <= S_IDLE;
      dropDP   <= 1'b0;
      opADP    <= {C_WIDTH{1'b0}};
      opBDP    <= {C_WIDTH{1'b0}};
      opCodeDP <= 2'b00;
      tagDP    <= {C_TAG_WIDTH{1'b0}};
      resDP    <= {C_WIDTH{1'b0}};
    end else begin
      stateDP  <= stateDN;
      dropDP   <= dropDN;
      opADP    <= opADN;
      opBDP    <= opBDN;
      opCodeDP <= opCodeDN;
      tagDP    <= tagDN;
      resDP    <= resDN;
    end
  end

  assign Bus.ReqRdy_SO   = reqRdy_S;
  assign Bus.RspVld_SO   = rspVld_S;
  assign Bus.RspRes_DO   = resDP;
  assign Bus.RspTag_DO   = tagDP;
  assign DivOpA_DO       = opADP;
  assign DivOpB_DO       = opBDP << shift_S;
  assign DivOpBShift_DO  = shift_S;
  assign DivOpBIsZero_SO = opBZero_S;
  assign DivOpBSign_SO   = opBSign_S;
  assign DivOpCode_SO    = opCodeDP;
  assign DivInVld_SO     = divInVld_S;
  assign DivOutRdy_SO    = divOutRdy_S;
  assign Busy_SO         = (stateDP != S_IDLE);
endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Self-checking bench for riscv_div_ctrl with a behavioural serial-divider stand-in.
module tb_riscv_div_ctrl;
  import riscv_defines::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          shift;
    logic [31:0] opBSh;
    logic        sign;
    logic        zero;
    logic [31:0] res;
  } vec_t;

  logic        clk, rst_n;
  logic [31:0] divOpA, divOpB, divRes;
  logic [5:0]  divShift;
  logic        divZero, divSign, divInVld, divOutRdy, divOutVld, busy;
  logic [1:0]  divOpCode;

  int nAssert = 0;
  int nFail   = 0;
  int ackCnt  = 0;

  logic [31:0] expA, expOpBSh, expRes;
  logic [1:0]  expOp;
  int          expShift;
  logic        expSign, expZero;

  vec_t tbl [10];

  riscv_div_ctrl_if #(.C_WIDTH(32), .C_TAG_WIDTH(5)) bus ();

  riscv_div_ctrl #(.C_WIDTH(32), .C_LOG_WIDTH(6), .C_TAG_WIDTH(5)) dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .Bus             (bus),
    .DivOpA_DO       (divOpA),
    .DivOpB_DO       (divOpB),
    .DivOpBShift_DO  (divShift),
    .DivOpBIsZero_SO (divZero),
    .DivOpBSign_SO   (divSign),
    .DivOpCode_SO    (divOpCode),
    .DivInVld_SO     (divInVld),
    .DivOutRdy_SO    (divOutRdy),
    .DivOutVld_SI    (divOutVld),
    .DivRes_DI       (divRes),
    .Busy_SO         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Normalising shift from the divisor's magnitude: log2 arithmetic, no bit scanning
  function automatic int ref_lz(input logic [1:0] op, input logic [31:0] b);
    logic [32:0] x;
    if (b == 32'd0) return 31;
    if (op[0] && b[31]) begin
      x = {1'b0, ~b} + 33'd1;
      return 31 - $clog2(x);
    end
    x = {1'b0, b} + 33'd1;
    return 32 - $clog2(x);
  endfunction

  // RISC-V M-extension division semantics, computed in 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (b == 32'd0) return (op[1]) ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0:    return 32'(ua / ub);
      2'd1:    return 32'(sa / sb);
      2'd2:    return 32'(ua % ub);
      default: return 32'(sa % sb);
    endcase
  endfunction

  task automatic setup(input vec_t v);
    expA = v.a; expOp = v.op; expOpBSh = v.opBSh; expShift = v.shift;
    expSign = v.sign; expZero = v.zero; expRes = v.res;
  endtask

  task automatic drive_req(input vec_t v);
    bus.ReqVld_SI = 1'b1; bus.ReqOpA_DI = v.a; bus.ReqOpB_DI = v.b;
    bus.ReqOpCode_SI = v.op; bus.ReqTag_DI = v.tag;
  endtask

  task automatic do_txn(input vec_t v, input int hold, input string nm);
    int cyc;
    setup(v);
    @(negedge clk);
    chk({nm, "_req_rdy_idle"}, bus.ReqRdy_SO, 1);
    drive_req(v);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.ReqVld_SI = 1'b0;
    while (!bus.RspVld_SO && cyc < 200) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk({nm, "_latency"}, cyc, v.shift + 4);
    chk({nm, "_rsp_res"}, bus.RspRes_DO, v.res);
    chk({nm, "_rsp_tag"}, bus.RspTag_DO, v.tag);
    chk({nm, "_req_rdy_resp"}, bus.ReqRdy_SO, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_vld"}, bus.RspVld_SO, 1);
      chk({nm, "_hold_res"}, bus.RspRes_DO, v.res);
      chk({nm, "_hold_tag"}, bus.RspTag_DO, v.tag);
      chk({nm, "_hold_req_rdy"}, bus.ReqRdy_SO, 0);
    end
    bus.RspRdy_SI = 1'b1;
    @(negedge clk);
    bus.RspRdy_SI = 1'b0;
    chk({nm, "_rsp_done"}, bus.RspVld_SO, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic flush_seq(input vec_t v, input int dly, input string nm);
    int  acks0;
    logic seen;
    setup(v);
    acks0 = ackCnt;
    @(negedge clk);
    drive_req(v);
    @(posedge clk);
    @(negedge clk);
    bus.ReqVld_SI = 1'b0;
    repeat (dly) @(negedge clk);
    bus.Flush_SI = 1'b1;
    @(negedge clk);
    bus.Flush_SI = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < v.shift + 8; i++) begin
      @(negedge clk);
      if (bus.RspVld_SO) seen = 1'b1;
    end
    chk({nm, "_no_rsp"}, seen, 0);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_acked"}, ackCnt - acks0, 1);
  endtask

  // Stand-in for riscv_alu_div: checks the issued operands and answers lz+2 cycles later
  initial begin
    logic aborted;
    divOutVld = 1'b0;
    divRes    = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && divInVld) begin
        chk("issue_opA", divOpA, expA);
        chk("issue_opB", divOpB, expOpBSh);
        chk("issue_shift", divShift, expShift);
        chk("issue_sign", divSign, expSign);
        chk("issue_zero", divZero, expZero);
        chk("issue_opcode", divOpCode, expOp);
        chk("issue_out_rdy", divOutRdy, 0);
        aborted = 1'b0;
        for (int k = 0; k < expShift + 2; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (k == 0) chk("in_vld_one_cycle", divInVld, 0);
        end
        if (!aborted) begin
          divOutVld = 1'b1;
          divRes    = expRes;
          #1;
          chk("div_out_rdy", divOutRdy, 1);
          ackCnt++;
          @(negedge clk);
          divOutVld = 1'b0;
          divRes    = 32'd0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    nFail++;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   sel;
    logic seen;
    tbl[0] = '{2'd0, 32'd100,        32'd7,          5'd3,  29, 32'hE000_0000, 1'b0, 1'b0, 32'd14};
    tbl[1] = '{2'd3, 32'hFFFF_FFF9,  32'd2,          5'd7,  30, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF};
    tbl[2] = '{2'd1, 32'd5,          32'd0,          5'd1,  31, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tbl[3] = '{2'd2, 32'd5,          32'd0,          5'd2,  31, 32'h0000_0000, 1'b0, 1'b1, 32'd5};
    tbl[4] = '{2'd1, 32'd9,          32'hFFFF_FFFF,  5'd31, 31, 32'h8000_0000, 1'b1, 1'b0, 32'hFFFF_FFF7};
    tbl[5] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 31, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000};
    tbl[6] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 31, 32'h8000_0000, 1'b1, 1'b0, 32'd0};
    tbl[7] = '{2'd1, 32'd100,        32'hFFFF_FFF8,  5'd12, 28, 32'h8000_0000, 1'b1, 1'b0, 32'hFFFF_FFF4};
    tbl[8] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFF8,  5'd13, 0,  32'hFFFF_FFF8, 1'b0, 1'b0, 32'h8000_0000};
    tbl[9] = '{2'd0, 32'hFFFF_FFFF,  32'd1,          5'd0,  31, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF};

    rst_n = 1'b0;
    bus.ReqVld_SI = 1'b0; bus.ReqOpA_DI = 32'd0; bus.ReqOpB_DI = 32'd0;
    bus.ReqOpCode_SI = 2'd0; bus.ReqTag_DI = 5'd0; bus.Flush_SI = 1'b0; bus.RspRdy_SI = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", bus.ReqRdy_SO, 1);
    chk("rst_rsp_vld", bus.RspVld_SO, 0);
    chk("rst_in_vld", divInVld, 0);
    chk("rst_out_rdy", divOutRdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_res", bus.RspRes_DO, 0);
    chk("rst_rsp_tag", bus.RspTag_DO, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i], (i == 0) ? 10 : 1, $sformatf("vec%0d", i));
    end

    // Flush arriving together with a request in IDLE blocks the request
    @(negedge clk);
    drive_req(tbl[0]);
    bus.Flush_SI = 1'b1;
    #1;
    chk("flush_idle_req_rdy", bus.ReqRdy_SO, 0);
    @(negedge clk);
    bus.ReqVld_SI = 1'b0;
    bus.Flush_SI  = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_in_vld", divInVld, 0);

    flush_seq(tbl[9], 0, "flush_issue");
    flush_seq(tbl[0], 2, "flush_wait");
    do_txn(tbl[1], 0, "after_flush");

    // Flush while the response is pending
    setup(tbl[3]);
    @(negedge clk);
    drive_req(tbl[3]);
    @(posedge clk);
    @(negedge clk);
    bus.ReqVld_SI = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = bus.RspVld_SO;
    end
    chk("flush_resp_vld_before", seen, 1);
    bus.Flush_SI = 1'b1;
    @(negedge clk);
    bus.Flush_SI = 1'b0;
    chk("flush_resp_vld_after", bus.RspVld_SO, 0);
    chk("flush_resp_busy", busy, 0);

    // Reset while waiting on the divider
    setup(tbl[0]);
    @(negedge clk);
    drive_req(tbl[0]);
    @(posedge clk);
    @(negedge clk);
    bus.ReqVld_SI = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req_rdy", bus.ReqRdy_SO, 1);
    chk("rst_wait_rsp_vld", bus.RspVld_SO, 0);
    chk("rst_wait_in_vld", divInVld, 0);
    chk("rst_wait_out_rdy", divOutRdy, 0);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_rsp_res", bus.RspRes_DO, 0);
    chk("rst_wait_rsp_tag", bus.RspTag_DO, 0);
    chk("rst_wait_opA", divOpA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_txn(tbl[4], 0, "after_rst");

    // Randomised operations against the reference model
    for (int n = 0; n < 40; n++) begin
      v.op  = 2'($urandom_range(0, 3));
      v.a   = $urandom;
      v.tag = 5'($urandom_range(0, 31));
      sel   = $urandom_range(0, 5);
      case (sel)
        0:       v.b = 32'd0;
        1:       v.b = 32'hFFFF_FFFF;
        2:       v.b = 32'($urandom_range(1, 20));
        3:       v.b = 32'd0 - 32'($urandom_range(1, 20));
        default: v.b = $urandom;
      endcase
      if (sel == 4) v.a = 32'h8000_0000;
      v.shift = ref_lz(v.op, v.b);
      v.opBSh = v.b << v.shift;
      v.sign  = v.op[0] & v.b[31];
      v.zero  = (v.b == 32'd0);
      v.res   = ref_res(v.op, v.a, v.b);
      do_txn(v, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/riscv_div_ctrl.md
RISCV_DIV_CTRL -- requirements
Module: riscv_div_ctrl

Interface
REQ-001 SHALL have parameter C_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter C_LOG_WIDTH, default 6, shift-count width, equal to $clog2(C_WIDTH+1).
REQ-003 SHALL have parameter C_TAG_WIDTH, default 5, destination-register tag width.
REQ-004 Clk_CI  in  1  single clock; all state changes on the rising edge.
REQ-005 Rst_RBI  in  1  reset, asynchronous, active-low.
REQ-006 ReqVld_SI / ReqRdy_SO  in / out  1 / 1  request handshake.
REQ-007 ReqOpA_DI, ReqOpB_DI  in  C_WIDTH  dividend, divisor.
REQ-008 ReqOpCode_SI  in  2  0 udiv, 1 div, 2 urem, 3 rem.
REQ-009 ReqTag_DI  in  C_TAG_WIDTH  tag, returned with the result.
REQ-010 Flush_SI  in  1  abort the in-flight operation.
REQ-011 RspVld_SO / RspRdy_SI  out / in  1 / 1  response handshake.
REQ-012 RspRes_DO  out  C_WIDTH; RspTag_DO  out  C_TAG_WIDTH.
REQ-013 DivOpA_DO, DivOpB_DO  out  C_WIDTH; DivOpBShift_DO  out  C_LOG_WIDTH; DivOpBIsZero_SO, DivOpBSign_SO  out  1; DivOpCode_SO  out  2  serial-divider operands.
REQ-014 DivInVld_SO  out  1; DivOutRdy_SO  out  1; DivOutVld_SI  in  1; DivRes_DI  in  C_WIDTH  serial-divider handshake and result.
REQ-015 Busy_SO  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-017 IDLE: ReqRdy_SO = ~Flush_SI; on ReqVld_SI & ReqRdy_SO, register opA, opB, opcode and tag, then go to ISSUE.
REQ-018 ISSUE: DivInVld_SO=1 for exactly one cycle; next state WAIT unconditionally.
REQ-019 WAIT: DivOutVld_SI is honoured only in WAIT, and only from the cycle after ISSUE. On DivOutVld_SI, DivOutRdy_SO=1 in the same cycle, DivRes_DI is captured into the result register, and the next state is RESP.
REQ-020 RESP: RspVld_SO=1 with stable RspRes_DO and RspTag_DO; on RspRdy_SI go to IDLE. No new request is accepted in that cycle.
REQ-021 DivOutRdy_SO SHALL be 0 outside WAIT. DivInVld_SO SHALL be 0 outside ISSUE.
REQ-022 Sign: DivOpBSign_SO = ReqOpCode[0] & opB[C_WIDTH-1].
REQ-023 Zero: DivOpBIsZero_SO = (opB == 0).
REQ-024 Shift, sign 0, opB nonzero: lz = count of leading zeros of opB.
REQ-025 Shift, sign 1: lz = (count of leading ones of opB) - 1.
REQ-026 Shift, opB zero: lz = C_WIDTH-1.
REQ-027 Outputs: DivOpB_DO = opB << lz (logical); DivOpBShift_DO = lz; DivOpA_DO and DivOpCode_SO are the registered values.
REQ-028 The shift count SHALL be computed combinationally from the registered operand during ISSUE, with no extra cycle.
REQ-029 Latency, with a compliant divider: RspVld_SO rises lz+4 cycles after the request handshake cycle.
REQ-030 Flush in ISSUE or WAIT sets a Drop flag. When the divider result arrives, it is acknowledged (DivOutRdy_SO=1) and discarded, and the FSM returns to IDLE with no response.
REQ-031 Flush in RESP: RspVld_SO is deasserted the next cycle and the FSM goes to IDLE.
REQ-032 Flush and ReqVld_SI in the same IDLE cycle: the request is not accepted.
REQ-033 Flush SHALL NOT be able to abort the divider itself.
REQ-034 The Drop flag clears on entry to IDLE.

Reset
REQ-035 On reset: state is IDLE and all registers are 0.
REQ-036 Reset values: ReqRdy_SO=1, RspVld_SO=0, DivInVld_SO=0, DivOutRdy_SO=0, Busy_SO=0, RspRes_DO=0, RspTag_DO=0.
REQ-037 Reset mid-operation abandons the operation with no response. The divider shares Rst_RBI and resets with this block.

Structure
REQ-038 The opcode encoding enum and the FSM state enum SHALL live in the shared riscv_defines package.
REQ-039 The leading-zero/leading-one counter SHALL be one sub-module, riscv_div_lzc, that is combinational and parameterised by C_WIDTH.
REQ-040 riscv_div_ctrl SHALL instantiate no divider. It connects to riscv_alu_div at the level above it.

Verification
REQ-041 udiv 100/7, tag 3: DivOpB_DO=0xE0000000, shift 29; response 14, tag 3, 33 cycles after handshake.
REQ-042 rem -7/2: sign 0, shift 30; response 0xFFFFFFFF.
REQ-043 div 5/0: DivOpBIsZero_SO=1, shift 31; response 0xFFFFFFFF. urem 5/0: response 5.
REQ-044 div 9/-1: DivOpBSign_SO=1, DivOpB_DO=0x80000000, shift 31; response 0xFFFFFFF7.
REQ-045 Flush asserted in WAIT: divider result acknowledged, RspVld_SO never rises; a following request completes normally.
REQ-046 RspRdy_SI held low for 10 cycles: RspVld_SO, RspRes_DO and RspTag_DO stay stable and ReqRdy_SO stays 0. Reset in WAIT: all outputs return to their reset values at once.
